// File: rtl/wb_spi_dac.sv
// rtl/wb_spi_dac.sv - Wishbone-controlled SPI master framing 24-bit words for the reference-tuning DAC
module wb_spi_dac #(
    parameter int          WB_ADDR_WIDTH   = 10,
    parameter int          CLK_DIV_DEFAULT = 10,
    parameter int          GAP_HALVES      = 6,
    parameter logic [17:0] RESET_WORD      = 18'h07F22
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic [31:0]              o_wb_data,
    output logic                     o_spi_sclk,
    output logic                     o_spi_mosi,
    output logic                     o_spi_sync_n,
    output logic                     o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t      r_state;
    logic [17:0] r_data;
    logic        r_pending;
    logic        r_repeat;
    logic [7:0]  r_div;
    logic [15:0] r_frames;
    logic [23:0] r_shift;
    logic [7:0]  r_h;
    logic [7:0]  r_cnt;
    logic [5:0]  r_halves;

    logic        w_acc;
    logic        w_wr;
    logic [1:0]  w_addr;
    logic        w_tick;
    logic [23:0] w_frame;
    logic        w_unused;

    assign o_wb_stall = 1'b0;
    assign w_acc      = i_wb_cyc & i_wb_stb;
    assign w_wr       = w_acc & i_wb_we;
    assign w_addr     = i_wb_addr[1:0];
    assign w_tick     = (r_cnt == r_h);
    assign w_frame    = {6'b0, r_data};
    assign w_unused   = ^{i_wb_sel, i_wb_addr, i_wb_data};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_data       <= RESET_WORD;
            r_pending    <= 1'b1;
            r_repeat     <= 1'b0;
            r_div        <= 8'(CLK_DIV_DEFAULT);
            r_frames     <= 16'd0;
            r_shift      <= 24'd0;
            r_h          <= 8'd0;
            r_cnt        <= 8'd0;
            r_halves     <= 6'd0;
            o_wb_ack     <= 1'b0;
            o_wb_data    <= 32'd0;
            o_spi_sclk   <= 1'b1;
            o_spi_mosi   <= 1'b0;
            o_spi_sync_n <= 1'b1;
            o_busy       <= 1'b0;
        end else begin
            o_wb_ack <= w_acc;
            if (w_acc) begin
                case (w_addr)
                    2'd0:    o_wb_data <= {14'd0, r_data};
                    2'd1:    o_wb_data <= {22'd0, r_pending, o_busy, 7'd0, r_repeat};
                    2'd2:    o_wb_data <= {24'd0, r_div};
                    default: o_wb_data <= {16'd0, r_frames};
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending || r_repeat) begin
                        r_shift      <= w_frame;
                        r_h          <= r_div;
                        r_cnt        <= 8'd0;
                        r_halves     <= 6'd0;
                        r_pending    <= 1'b0;
                        o_spi_sync_n <= 1'b0;
                        o_spi_mosi   <= w_frame[23];
                        o_spi_sclk   <= 1'b1;
                        o_busy       <= 1'b1;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_cnt <= 8'd0;
                        // Half 47 is the closing half after falling edge 24: end the frame.
                        if (r_halves == 6'd47) begin
                            r_halves     <= 6'd0;
                            o_spi_sclk   <= 1'b1;
                            o_spi_sync_n <= 1'b1;
                            o_spi_mosi   <= 1'b0;
                            r_frames     <= r_frames + 16'd1;
                            r_state      <= S_GAP;
                        end else begin
                            r_halves   <= r_halves + 6'd1;
                            o_spi_sclk <= ~o_spi_sclk;
                            if (r_halves[0]) begin
                                r_shift    <= {r_shift[22:0], 1'b0};
                                o_spi_mosi <= r_shift[22];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_cnt <= 8'd0;
                        if (r_halves == 6'(GAP_HALVES - 1)) begin
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_halves <= r_halves + 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase

            // Bus writes come last so a DATA write in a start cycle keeps PENDING set.
            if (w_wr) begin
                case (w_addr)
                    2'd0: begin
                        r_data    <= i_wb_data[17:0];
                        r_pending <= 1'b1;
                    end
                    2'd1:    r_repeat <= i_wb_data[0];
                    2'd2:    r_div    <= i_wb_data[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
